// File: rtl/branch_pkg.sv
// Shared definitions for the multi-cycle RV32I branch comparator:
// funct3 encodings, FSM state type and funct3 decode helpers.
package branch_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } br_state_t;

  function automatic logic is_signed_br(input logic [2:0] funct3);
    return (funct3 == BR_BLT) || (funct3 == BR_BGE);
  endfunction

  function automatic logic is_illegal_br(input logic [2:0] funct3);
    return funct3[2:1] == 2'b01;
  endfunction

  function automatic logic br_taken(input logic [2:0] funct3, input logic eq, input logic lt);
    case (funct3)
      BR_BEQ:           return eq;
      BR_BNE:           return !eq;
      BR_BLT, BR_BLTU:  return lt;
      BR_BGE, BR_BGEU:  return !lt;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit operand slice.
module branch_chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  output logic             o_lt,
  output logic             o_eq
);

  assign o_lt = (i_a < i_b);
  assign o_eq = (i_a == i_b);

endmodule

// File: rtl/branch_compare_seq.sv
// Multi-cycle branch comparator: scans operands MSB-first CHUNK bits per
// cycle and resolves all six conditional-branch funct3 modes.
module branch_compare_seq
  import branch_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_rs1Data,
  input  logic [WIDTH-1:0] i_rs2Data,
  input  logic [2:0]       i_brFunct,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_brEqual,
  output logic             o_brLess,
  output logic             o_taken,
  output logic             o_illegal
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("branch_compare_seq: CHUNK must divide WIDTH");
  end

  br_state_t        state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       funct_q;
  logic             ill_q;
  logic             diff_seen, diff_lt;

  logic [WIDTH-1:0] sign_flip;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             chunk_lt, chunk_eq;
  logic             fin, fin_eq, fin_lt;

  // Flipping the sign bit of both operands maps signed order onto unsigned order.
  assign sign_flip = {is_signed_br(i_brFunct), {(WIDTH-1){1'b0}}};

  assign a_chunk = a_q[int'(idx)*CHUNK +: CHUNK];
  assign b_chunk = b_q[int'(idx)*CHUNK +: CHUNK];

  branch_chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .i_a  (a_chunk),
    .i_b  (b_chunk),
    .o_lt (chunk_lt),
    .o_eq (chunk_eq)
  );

  always_comb begin
    fin    = 1'b0;
    fin_eq = 1'b0;
    fin_lt = 1'b0;
    if (ill_q) begin
      fin = 1'b1;
    end else if (EARLY_EXIT != 0 && !chunk_eq) begin
      fin    = 1'b1;
      fin_lt = chunk_lt;
    end else if (idx == '0) begin
      fin    = 1'b1;
      fin_eq = !diff_seen && chunk_eq;
      fin_lt = diff_seen ? diff_lt : chunk_lt;
    end
  end

  assign o_ready = (state == IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      funct_q   <= '0;
      ill_q     <= 1'b0;
      diff_seen <= 1'b0;
      diff_lt   <= 1'b0;
      o_valid   <= 1'b0;
      o_brEqual <= 1'b0;
      o_brLess  <= 1'b0;
      o_taken   <= 1'b0;
      o_illegal <= 1'b0;
    end else if (i_flush) begin
      state     <= IDLE;
      idx       <= '0;
      o_valid   <= 1'b0;
      o_brEqual <= 1'b0;
      o_brLess  <= 1'b0;
      o_taken   <= 1'b0;
      o_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            // Illegal funct3 spends one CMP cycle so its latency is 1 like the fastest compare.
            a_q       <= i_rs1Data ^ sign_flip;
            b_q       <= i_rs2Data ^ sign_flip;
            funct_q   <= i_brFunct;
            ill_q     <= is_illegal_br(i_brFunct);
            idx       <= IDXW'(NCHUNK - 1);
            diff_seen <= 1'b0;
            diff_lt   <= 1'b0;
            state     <= CMP;
          end
        end
        CMP: begin
          if (!diff_seen && !chunk_eq) begin
            diff_seen <= 1'b1;
            diff_lt   <= chunk_lt;
          end
          if (fin) begin
            state     <= DONE;
            o_valid   <= 1'b1;
            o_brEqual <= fin_eq;
            o_brLess  <= fin_lt;
            o_taken   <= !ill_q && br_taken(funct_q, fin_eq, fin_lt);
            o_illegal <= ill_q;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            state     <= IDLE;
            o_valid   <= 1'b0;
            o_brEqual <= 1'b0;
            o_brLess  <= 1'b0;
            o_taken   <= 1'b0;
            o_illegal <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_compare_seq.sv
// Self-checking bench: several parameterisations driven in lockstep and
// compared against an arithmetic reference model.
module tb_branch_compare_seq;
  import branch_pkg::*;

  localparam int NI = 7;

  function automatic int w_of(input int g);
    case (g)
      0, 1, 5: return 32;
      2, 3:    return 16;
      default: return 64;
    endcase
  endfunction

  function automatic int c_of(input int g);
    case (g)
      0, 1:    return 8;
      2, 6:    return 1;
      3:       return 4;
      default: return 32;
    endcase
  endfunction

  function automatic int ee_of(input int g);
    case (g)
      0, 2, 4: return 1;
      default: return 0;
    endcase
  endfunction

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic          flush = 1'b0;
  logic          ready = 1'b0;
  logic [2:0]    funct = '0;
  logic [63:0]   rs1 = '0, rs2 = '0;
  logic [NI-1:0] ordy, ov, oeq, olt, otk, oill;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = w_of(g);
    branch_compare_seq #(.WIDTH(W), .CHUNK(c_of(g)), .EARLY_EXIT(ee_of(g))) u_dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_valid   (valid),
      .o_ready   (ordy[g]),
      .i_rs1Data (rs1[W-1:0]),
      .i_rs2Data (rs2[W-1:0]),
      .i_brFunct (funct),
      .i_flush   (flush),
      .o_valid   (ov[g]),
      .i_ready   (ready),
      .o_brEqual (oeq[g]),
      .o_brLess  (olt[g]),
      .o_taken   (otk[g]),
      .o_illegal (oill[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  int   got_lat [NI];
  logic got_eq  [NI];
  logic got_lt  [NI];
  logic got_tk  [NI];
  logic got_ill [NI];

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int g, input logic [2:0] f,
                                input logic [63:0] a_in, input logic [63:0] b_in,
                                output bit eq, output bit lt, output bit tk,
                                output bit ill, output int lat);
    int w = w_of(g);
    int n = w / c_of(g);
    int msb = 0;
    logic [63:0] mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    logic [63:0] a = a_in & mask;
    logic [63:0] b = b_in & mask;
    logic [63:0] x = a ^ b;
    ill = (f == 3'b010) || (f == 3'b011);
    eq  = (a == b);
    if (f == BR_BLT || f == BR_BGE)
      lt = $signed(a << (64 - w)) < $signed(b << (64 - w));
    else
      lt = (a < b);
    for (int i = 63; i >= 0; i--)
      if (x[i]) begin msb = i; break; end
    lat = (x == 0 || ee_of(g) == 0) ? n : n - msb / c_of(g);
    case (f)
      BR_BEQ:          tk = eq;
      BR_BNE:          tk = !eq;
      BR_BLT, BR_BLTU: tk = lt;
      default:         tk = !lt;
    endcase
    if (ill) begin
      eq = 0; lt = 0; tk = 0; lat = 1;
    end
  endfunction

  task automatic run_txn(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    bit all_done;
    bit meq, mlt, mtk, mill;
    int mlat;
    @(negedge clk);
    funct = f; rs1 = a; rs2 = b; valid = 1'b1; ready = 1'b0;
    for (int g = 0; g < NI; g++) check($sformatf("ready_idle_g%0d", g), ordy[g], 1);
    @(posedge clk); #1;
    valid = 1'b0;
    for (int g = 0; g < NI; g++) got_lat[g] = -1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      all_done = 1;
      for (int g = 0; g < NI; g++) begin
        if (got_lat[g] < 0 && ov[g]) got_lat[g] = c;
        if (got_lat[g] < 0) all_done = 0;
      end
      if (all_done) break;
    end
    for (int g = 0; g < NI; g++) begin
      got_eq[g] = oeq[g]; got_lt[g] = olt[g]; got_tk[g] = otk[g]; got_ill[g] = oill[g];
      model(g, f, a, b, meq, mlt, mtk, mill, mlat);
      check($sformatf("lat_g%0d_f%0d", g, f), got_lat[g], mlat);
      check($sformatf("eq_g%0d_f%0d", g, f), oeq[g], meq);
      check($sformatf("lt_g%0d_f%0d", g, f), olt[g], mlt);
      check($sformatf("tk_g%0d_f%0d", g, f), otk[g], mtk);
      check($sformatf("ill_g%0d_f%0d", g, f), oill[g], mill);
    end
    @(negedge clk); ready = 1'b1;
    @(posedge clk); #1; ready = 1'b0;
    for (int g = 0; g < NI; g++) begin
      check($sformatf("post_hs_valid_g%0d", g), ov[g], 0);
      check($sformatf("post_hs_ready_g%0d", g), ordy[g], 1);
      check($sformatf("post_hs_res_g%0d", g), {oeq[g], olt[g], otk[g], oill[g]}, 0);
    end
  endtask

  initial begin
    logic [2:0]  rf;
    logic [63:0] ra, rb;
    bit          seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      check($sformatf("rst_ready_g%0d", g), ordy[g], 1);
      check($sformatf("rst_outs_g%0d", g), {ov[g], oeq[g], olt[g], otk[g], oill[g]}, 0);
    end
    @(negedge clk); rst_n = 1'b1;

    // Directed cases
    run_txn(BR_BEQ, 64'h12345678, 64'h12345678);
    check("beq_lat", got_lat[0], 4);
    check("beq_eq", got_eq[0], 1);
    check("beq_tk", got_tk[0], 1);
    run_txn(BR_BLT, 64'hFFFFFFFF, 64'h1);
    check("blt_lat", got_lat[0], 1);
    check("blt_lt", got_lt[0], 1);
    check("blt_tk", got_tk[0], 1);
    check("blt_ee0_lat", got_lat[1], 4);
    run_txn(BR_BLTU, 64'hFFFFFFFF, 64'h1);
    check("bltu_lat", got_lat[0], 1);
    check("bltu_tk", got_tk[0], 0);
    run_txn(BR_BNE, 64'hFF, 64'hFE);
    check("bne_lat", got_lat[0], 4);
    check("bne_tk", got_tk[0], 1);
    check("bne_ee0_tk", got_tk[1], 1);
    run_txn(BR_BGEU, 64'hFF, 64'hFE);
    check("bgeu_lt", got_lt[0], 0);
    check("bgeu_tk", got_tk[0], 1);
    check("bgeu_ee0_lat", got_lat[1], 4);
    run_txn(3'b010, 64'h5, 64'h5);
    check("illegal_flag", got_ill[0], 1);
    check("illegal_tk", got_tk[0], 0);
    check("illegal_lat", got_lat[0], 1);

    // Backpressure: result held, second request ignored until handshake
    @(negedge clk);
    funct = BR_BEQ; rs1 = 64'h12345678; rs2 = 64'h12345678; valid = 1'b1; ready = 1'b0;
    @(posedge clk); #1;
    funct = BR_BNE; rs1 = 64'hFF; rs2 = 64'hFE;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #1;
      seen = ov[0];
    end
    check("bp_valid_rise", ov[0], 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", ov[0], 1);
      check("bp_hold_ready", ordy[0], 0);
      check("bp_hold_eq", oeq[0], 1);
      check("bp_hold_tk", otk[0], 1);
    end
    for (int c = 0; c < 80 && ov != '1; c++) @(posedge clk);
    #1;
    check("bp_all_valid", ov, {NI{1'b1}});
    @(negedge clk); ready = 1'b1;
    @(posedge clk); #1; ready = 1'b0;
    check("bp_release_ready", ordy, {NI{1'b1}});
    check("bp_release_valid", ov, 0);
    run_txn(BR_BNE, 64'hFF, 64'hFE);
    check("bp_held_tk", got_tk[0], 1);

    // Flush in the second CMP cycle
    @(negedge clk);
    funct = BR_BEQ; rs1 = 64'hCAFEF00D12345678; rs2 = 64'hCAFEF00D12345678; valid = 1'b1;
    @(posedge clk); #1; valid = 1'b0;
    @(posedge clk); #1; flush = 1'b1;
    check("flush_pre_valid", ov[1:0], 0);
    @(posedge clk); #1; flush = 1'b0;
    check("flush_ready", ordy, {NI{1'b1}});
    check("flush_valid", ov, 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("flush_no_pulse", ov, 0);
    end

    // Flush beats a simultaneous request in IDLE
    @(negedge clk); valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1; valid = 1'b0; flush = 1'b0;
    check("flush_idle_ready", ordy, {NI{1'b1}});
    repeat (3) @(posedge clk);
    #1;
    check("flush_idle_valid", ov, 0);

    // Asynchronous reset mid-compare
    @(negedge clk);
    funct = BR_BLTU; rs1 = 64'h5; rs2 = 64'h5; valid = 1'b1;
    @(posedge clk); #1; valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_outs", {ov, oeq, olt, otk, oill}, 0);
    check("arst_ready", ordy, {NI{1'b1}});
    @(negedge clk); rst_n = 1'b1;
    run_txn(BR_BGE, 64'h80000000, 64'h7FFFFFFF);
    check("post_rst_bge_lt", got_lt[0], 1);
    check("post_rst_bge_tk", got_tk[0], 0);

    // Randomised sweep over all parameterisations
    for (int t = 0; t < 60; t++) begin
      rf = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (64'd1 << $urandom_range(0, 63));
        default: rb = {$urandom, $urandom};
      endcase
      run_txn(rf, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_compare_seq.md
Name: branch_compare_seq

Overview:
Parametrised, multi-cycle branch comparator for the RV32I execute stage. It resolves all six conditional-branch funct3 modes and outputs equal, less and taken. Operands are scanned MSB-first, CHUNK bits per cycle, with optional early exit on the first differing chunk. A valid/ready handshake on both sides lets it sit between the issue and branch-resolve stages. Narrow comparators cost a few cycles of latency per branch in exchange for a short timing path.

Parameters:
WIDTH, 32, operand width in bits
CHUNK, 8, bits compared per cycle; must divide WIDTH (elaboration-time assertion)
EARLY_EXIT, 1, 1 = finish on the first differing chunk; 0 = always scan all chunks
NCHUNK, WIDTH/CHUNK, derived localparam; not overridable

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  request valid
o_ready  out  1  block can accept a request
i_rs1Data  in  WIDTH  operand A
i_rs2Data  in  WIDTH  operand B
i_brFunct  in  3  funct3: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111
i_flush  in  1  synchronous kill of in-flight or held request
o_valid  out  1  result valid
i_ready  in  1  consumer accepts result
o_brEqual  out  1  A == B
o_brLess  out  1  A < B, signed or unsigned per funct
o_taken  out  1  branch decision
o_illegal  out  1  funct3 is 010 or 011

Behaviour:
- FSM states: IDLE, CMP, DONE.
- Reset (asynchronous, i_rst_n low): state=IDLE, o_valid=0, o_brEqual=0, o_brLess=0, o_taken=0, o_illegal=0, chunk index=0. o_ready=1 once state is IDLE.
- o_ready = (state==IDLE). Requests are accepted only on an edge where i_valid && o_ready && !i_flush.
- Accept: capture the operands and funct3. For BLT/BGE, invert bit WIDTH-1 of both operands, so that signed order becomes unsigned order. Set idx=NCHUNK-1 and go to CMP.
- Illegal funct3 (010, 011): go directly to DONE with o_illegal=1, taken=0, equal=0, less=0. Latency is 1.
- CMP, each cycle: compare chunk idx of A and B.
  - EARLY_EXIT=1, chunks differ: less=(A_chunk<B_chunk), equal=0, go to DONE.
  - Chunks equal and idx==0: equal=1, less=0, go to DONE.
  - Otherwise: idx decrements.
  - EARLY_EXIT=0: the first difference is latched into sticky regs and later chunks are ignored. DONE is entered only after idx==0.
- Latency from the accept edge to o_valid high = number of chunks examined: 1..NCHUNK, or exactly NCHUNK when EARLY_EXIT=0. CHUNK=WIDTH gives latency 1.
- taken: BEQ=equal, BNE=!equal, BLT/BLTU=less, BGE/BGEU=!less.
- DONE: o_valid=1. All result outputs are registered and stable until handshake. On i_valid-independent i_ready high, go to IDLE at that edge; o_valid drops and o_ready rises the next cycle.
- Outputs outside DONE: o_valid=0. Result outputs are cleared to 0 on entering IDLE.
- i_flush:
  - Any state goes to IDLE at the next edge, and the request is discarded with no o_valid pulse.
  - Flush has priority over accept and over DONE handshake.
- A reset asserted mid-operation drops all state immediately. The first post-reset request behaves normally.
- New i_valid during CMP or DONE is ignored; the upstream holds it because o_ready=0.

Decomposition:
- Package branch_pkg:
  - funct3 localparams: BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU.
  - State enum br_state_t {IDLE, CMP, DONE}.
  - Function is_signed_br(funct3).
- Sub-module branch_chunk_cmp #(CHUNK): combinational unsigned compare of two CHUNK-bit slices, producing o_lt and o_eq. It is instantiated once and driven by an idx-indexed slice mux.

Test Plan:
- WIDTH=32, CHUNK=8, EARLY_EXIT=1. BEQ A=B=0x12345678 → equal=1, less=0, taken=1; o_valid high exactly 4 edges after accept.
- BLT A=0xFFFFFFFF, B=0x00000001 → less=1, taken=1, latency 1. Same operands with BLTU → less=0, taken=0, latency 1.
- BNE A=0x000000FF, B=0x000000FE → equal=0, taken=1, latency 4. BGEU on the same operands → less=0, taken=1. Repeat with EARLY_EXIT=0 → identical results, latency always 4.
- Backpressure: i_ready=0 for 5 cycles in DONE → o_valid and results stable, o_ready=0, and a second i_valid is not accepted. Raise i_ready → IDLE next cycle, then accept the held request.
- Kills and illegal funct:
  - i_flush in the 2nd CMP cycle → no o_valid pulse, o_ready=1 next cycle.
  - i_rst_n low mid-CMP → all outputs 0 immediately; the next BGE A=0x80000000, B=0x7FFFFFFF gives less=1, taken=0.
  - funct3=010 → o_illegal=1, taken=0, latency 1.
- Parameter sweep: CHUNK ∈ {1,4,8,32}, WIDTH ∈ {16,32,64} → random operands and all six functs match a reference model, and latency stays within 1..NCHUNK.
